// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFS_W     = 4;
    localparam int WORD_SEL_W = 2;
    localparam int LINE_W     = LINE_BYTES * 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WB_REQ  = 3'd1;
    localparam logic [2:0] ST_WB_WAIT = 3'd2;
    localparam logic [2:0] ST_RF_REQ  = 3'd3;
    localparam logic [2:0] ST_RF_WAIT = 3'd4;

    function automatic logic [31:0] line_addr(input logic [31:0] addr);
        return {addr[31:OFFS_W], {OFFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// LSU-side access port and line-RAM request port of the data cache.
interface dcache_if;
    import dcache_pkg::*;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [31:0]           cpu_addr;
    logic [3:0]            cpu_wstrb;
    logic [31:0]           cpu_wdata;
    logic [31:0]           cpu_rdata;
    logic                  cpu_ready;
    logic                  mem_rd_req;
    logic [31:0]           mem_rd_addr;
    logic                  mem_wb_req;
    logic [31:0]           mem_wb_addr;
    logic [LINE_W-1:0]     mem_wb_data;
    logic [LINE_W-1:0]     mem_data;
    logic                  mem_ready;

    // master: the core and line RAM around the cache; slave: the cache itself
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wstrb, cpu_wdata, mem_data, mem_ready,
        input  cpu_rdata, cpu_ready, mem_rd_req, mem_rd_addr, mem_wb_req, mem_wb_addr, mem_wb_data
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wstrb, cpu_wdata, mem_data, mem_ready,
        output cpu_rdata, cpu_ready, mem_rd_req, mem_rd_addr, mem_wb_req, mem_wb_addr, mem_wb_data
    );

endinterface

// File: rtl/dcache_array.sv
// Flop-based line storage: valid/dirty/tag/data per line, async read, one byte-enabled write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 32 - OFFS_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [LINE_BYTES-1:0] wr_be,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  wr_dirty
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data need no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wr_be[b]) data_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
//   state      | meaning
//   ST_IDLE    | serve hits, detect misses
//   ST_WB_REQ  | one-cycle writeback request of dirty victim
//   ST_WB_WAIT | wait for RAM to accept victim line
//   ST_RF_REQ  | one-cycle refill request
//   ST_RF_WAIT | wait for refill data, install line
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64
) (
    input logic     clk,
    input logic     rst_n,
    dcache_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - OFFS_W - IDX_W;

    logic [2:0]              state_q, state_d;
    logic [31:0]             req_addr_q;
    logic [31:0]             wb_addr_q;
    logic [LINE_W-1:0]       wb_data_q;

    logic [IDX_W-1:0]        cpu_idx, req_idx;
    logic [TAG_W-1:0]        cpu_tag, req_tag;
    logic [WORD_SEL_W-1:0]   word_sel;
    logic                    rd_valid, rd_dirty;
    logic [TAG_W-1:0]        rd_tag;
    logic [LINE_W-1:0]       rd_data;
    logic                    hit, miss, fill;
    logic                    wr_en, wr_dirty;
    logic [IDX_W-1:0]        wr_idx;
    logic [LINE_BYTES-1:0]   wr_be;
    logic [LINE_W-1:0]       wr_data;
    logic [TAG_W-1:0]        wr_tag;
    logic                    unused_addr_bits;

    assign cpu_idx  = bus.cpu_addr[OFFS_W +: IDX_W];
    assign cpu_tag  = bus.cpu_addr[31 -: TAG_W];
    assign word_sel = bus.cpu_addr[3:2];
    assign req_idx  = req_addr_q[OFFS_W +: IDX_W];
    assign req_tag  = req_addr_q[31 -: TAG_W];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    dcache_array #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (cpu_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .wr_tag   (wr_tag),
        .wr_dirty (wr_dirty)
    );

    assign hit  = (state_q == ST_IDLE) && bus.cpu_req && rd_valid && (rd_tag == cpu_tag);
    assign miss = (state_q == ST_IDLE) && bus.cpu_req && !hit;
    assign fill = (state_q == ST_RF_WAIT) && bus.mem_ready;

    assign bus.cpu_ready   = hit;
    assign bus.cpu_rdata   = (hit && !bus.cpu_we) ? rd_data[{word_sel, 5'd0} +: 32] : 32'h0;
    assign bus.mem_rd_req  = (state_q == ST_RF_REQ);
    assign bus.mem_wb_req  = (state_q == ST_WB_REQ);
    assign bus.mem_rd_addr = req_addr_q;
    assign bus.mem_wb_addr = wb_addr_q;
    assign bus.mem_wb_data = wb_data_q;

    // Refill owns the write port in RF_WAIT; store hits can only occur in IDLE.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = cpu_idx;
        wr_be    = '0;
        wr_data  = {4{bus.cpu_wdata}};
        wr_tag   = cpu_tag;
        wr_dirty = 1'b1;
        if (fill) begin
            wr_en    = 1'b1;
            wr_idx   = req_idx;
            wr_be    = '1;
            wr_data  = bus.mem_data;
            wr_tag   = req_tag;
            wr_dirty = 1'b0;
        end else if (hit && bus.cpu_we) begin
            wr_en = 1'b1;
            wr_be = LINE_BYTES'(bus.cpu_wstrb) << {word_sel, 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (miss) state_d = (rd_valid && rd_dirty) ? ST_WB_REQ : ST_RF_REQ;
            ST_WB_REQ:  state_d = ST_WB_WAIT;
            ST_WB_WAIT: if (bus.mem_ready) state_d = ST_RF_REQ;
            ST_RF_REQ:  state_d = ST_RF_WAIT;
            ST_RF_WAIT: if (bus.mem_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_addr_q <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (miss) begin
                req_addr_q <= line_addr(bus.cpu_addr);
                wb_addr_q  <= {rd_tag, cpu_idx, {OFFS_W{1'b0}}};
                wb_data_q  <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed cycle-exact bench for dcache_ctrl with a behavioural line RAM.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int NUM_LINES = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [127:0] ram [logic [31:0]];

    dcache_if bus ();

    dcache_ctrl #(.NUM_LINES(NUM_LINES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Untouched RAM lines hold word k of line L = 0xA500_0000 | (L + 4k).
    function automatic logic [127:0] ram_default(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hA500_0000 | (la + 32'(4 * k));
        return l;
    endfunction

    function automatic logic [127:0] ram_read(input logic [31:0] la);
        if (ram.exists(la)) return ram[la];
        return ram_default(la);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_ready <= 1'b0;
            bus.mem_data  <= '0;
        end else begin
            bus.mem_ready <= 1'b0;
            if (bus.mem_rd_req) begin
                bus.mem_data  <= ram_read(bus.mem_rd_addr);
                bus.mem_ready <= 1'b1;
            end else if (bus.mem_wb_req) begin
                ram[bus.mem_wb_addr] = bus.mem_wb_data;
                bus.mem_ready <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a; bus.cpu_wstrb = 4'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wstrb = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wstrb = '0; bus.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        mid();
        chk("rst_ready",   128'(bus.cpu_ready),   128'h0);
        chk("rst_rdreq",   128'(bus.mem_rd_req),  128'h0);
        chk("rst_wbreq",   128'(bus.mem_wb_req),  128'h0);
        chk("rst_rdaddr",  128'(bus.mem_rd_addr), 128'h0);
        chk("rst_wbaddr",  128'(bus.mem_wb_addr), 128'h0);
        chk("rst_wbdata",  bus.mem_wb_data,       128'h0);
        chk("rst_rdata",   128'(bus.cpu_rdata),   128'h0);
        nxt();
        rst_n = 1'b1;

        // clean miss on 0x40
        load(32'h40);
        mid(); chk("t1_c0_ready", 128'(bus.cpu_ready), 128'h0);
               chk("t1_c0_rdreq", 128'(bus.mem_rd_req), 128'h0);
        nxt(); mid();
        chk("t1_c1_rdreq",  128'(bus.mem_rd_req),  128'h1);
        chk("t1_c1_rdaddr", 128'(bus.mem_rd_addr), 128'h40);
        chk("t1_c1_wbreq",  128'(bus.mem_wb_req),  128'h0);
        nxt(); mid();
        chk("t1_c2_rdreq",  128'(bus.mem_rd_req),  128'h0);
        chk("t1_c2_ready",  128'(bus.cpu_ready),   128'h0);
        nxt(); mid();
        chk("t1_c3_ready",  128'(bus.cpu_ready),   128'h1);
        chk("t1_c3_rdata",  128'(bus.cpu_rdata),   128'hA500_0040);
        nxt();

        // hit on neighbouring word
        load(32'h44);
        mid();
        chk("t2_ready", 128'(bus.cpu_ready),  128'h1);
        chk("t2_rdata", 128'(bus.cpu_rdata),  128'hA500_0044);
        chk("t2_rdreq", 128'(bus.mem_rd_req), 128'h0);
        chk("t2_wbreq", 128'(bus.mem_wb_req), 128'h0);
        nxt();

        // partial store hit then readback
        store(32'h40, 32'hDEAD_BEEF, 4'b0011);
        mid();
        chk("t3_st_ready", 128'(bus.cpu_ready),  128'h1);
        chk("t3_st_rdreq", 128'(bus.mem_rd_req), 128'h0);
        nxt();
        load(32'h40);
        mid();
        chk("t3_ld_ready", 128'(bus.cpu_ready), 128'h1);
        chk("t3_ld_rdata", 128'(bus.cpu_rdata), 128'hA500_BEEF);
        nxt();

        // dirty conflict miss on same index
        load(32'h40 + 32'(16 * NUM_LINES));
        mid(); chk("t4_c0_ready", 128'(bus.cpu_ready), 128'h0);
        nxt(); mid();
        chk("t4_c1_wbreq",  128'(bus.mem_wb_req),  128'h1);
        chk("t4_c1_wbaddr", 128'(bus.mem_wb_addr), 128'h40);
        chk("t4_c1_wbdata", bus.mem_wb_data, 128'hA500_004C_A500_0048_A500_0044_A500_BEEF);
        chk("t4_c1_rdreq",  128'(bus.mem_rd_req),  128'h0);
        nxt(); mid();
        chk("t4_c2_wbreq",  128'(bus.mem_wb_req),  128'h0);
        chk("t4_c2_wbaddr", 128'(bus.mem_wb_addr), 128'h40);
        chk("t4_c2_wbdata", bus.mem_wb_data, 128'hA500_004C_A500_0048_A500_0044_A500_BEEF);
        nxt(); mid();
        chk("t4_c3_rdreq",  128'(bus.mem_rd_req),  128'h1);
        chk("t4_c3_rdaddr", 128'(bus.mem_rd_addr), 128'h440);
        chk("t4_c3_wbreq",  128'(bus.mem_wb_req),  128'h0);
        nxt(); mid();
        chk("t4_c4_ready",  128'(bus.cpu_ready),   128'h0);
        nxt(); mid();
        chk("t4_c5_ready",  128'(bus.cpu_ready),   128'h1);
        chk("t4_c5_rdata",  128'(bus.cpu_rdata),   128'hA500_0440);
        chk("t4_ram_40",    ram_read(32'h40), 128'hA500_004C_A500_0048_A500_0044_A500_BEEF);
        nxt();

        // reset while in WB_WAIT
        store(32'h440, 32'h1234_5678, 4'hF);
        mid(); chk("t5_st_ready", 128'(bus.cpu_ready), 128'h1);
        nxt();
        load(32'h40);
        mid(); chk("t5_c0_ready", 128'(bus.cpu_ready), 128'h0);
        nxt(); mid();
        chk("t5_c1_wbreq",  128'(bus.mem_wb_req),  128'h1);
        chk("t5_c1_wbaddr", 128'(bus.mem_wb_addr), 128'h440);
        chk("t5_c1_wbdata", bus.mem_wb_data, 128'hA500_044C_A500_0448_A500_0444_1234_5678);
        nxt();
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        mid(); chk("t5_c2_wbreq", 128'(bus.mem_wb_req), 128'h0);
        nxt();
        rst_n = 1'b1;
        mid();
        chk("t5_post_ready",  128'(bus.cpu_ready),   128'h0);
        chk("t5_post_rdreq",  128'(bus.mem_rd_req),  128'h0);
        chk("t5_post_wbreq",  128'(bus.mem_wb_req),  128'h0);
        chk("t5_post_wbaddr", 128'(bus.mem_wb_addr), 128'h0);
        chk("t5_post_wbdata", bus.mem_wb_data,       128'h0);
        chk("t5_post_rdaddr", 128'(bus.mem_rd_addr), 128'h0);
        nxt();
        load(32'h44);
        mid(); chk("t5_rl_c0_ready", 128'(bus.cpu_ready), 128'h0);
        nxt(); mid();
        chk("t5_rl_c1_rdreq",  128'(bus.mem_rd_req),  128'h1);
        chk("t5_rl_c1_rdaddr", 128'(bus.mem_rd_addr), 128'h40);
        chk("t5_rl_c1_wbreq",  128'(bus.mem_wb_req),  128'h0);
        nxt(); nxt(); mid();
        chk("t5_rl_c3_ready",  128'(bus.cpu_ready),   128'h1);
        chk("t5_rl_c3_rdata",  128'(bus.cpu_rdata),   128'hA500_0044);
        nxt();

        // request dropped during refill
        load(32'h80);
        nxt(); mid();
        chk("t6_c1_rdreq",  128'(bus.mem_rd_req),  128'h1);
        chk("t6_c1_rdaddr", 128'(bus.mem_rd_addr), 128'h80);
        nxt();
        bus.cpu_req = 1'b0;
        mid(); chk("t6_c2_ready", 128'(bus.cpu_ready), 128'h0);
        nxt(); mid();
        chk("t6_c3_ready", 128'(bus.cpu_ready),  128'h0);
        chk("t6_c3_rdreq", 128'(bus.mem_rd_req), 128'h0);
        chk("t6_c3_wbreq", 128'(bus.mem_wb_req), 128'h0);
        nxt(); mid();
        chk("t6_c4_ready", 128'(bus.cpu_ready), 128'h0);
        nxt();
        load(32'h88);
        mid();
        chk("t6_hit_ready", 128'(bus.cpu_ready),  128'h1);
        chk("t6_hit_rdata", 128'(bus.cpu_rdata),  128'hA500_0088);
        chk("t6_hit_rdreq", 128'(bus.mem_rd_req), 128'h0);
        nxt();

        // zero-strobe store still marks the line dirty
        store(32'h88, 32'hFFFF_FFFF, 4'h0);
        mid(); chk("t7_st_ready", 128'(bus.cpu_ready), 128'h1);
        nxt();
        load(32'h88);
        mid(); chk("t7_ld_rdata", 128'(bus.cpu_rdata), 128'hA500_0088);
        nxt();
        load(32'h80 + 32'(16 * NUM_LINES));
        mid(); chk("t7_c0_ready", 128'(bus.cpu_ready), 128'h0);
        nxt(); mid();
        chk("t7_c1_wbreq",  128'(bus.mem_wb_req),  128'h1);
        chk("t7_c1_wbaddr", 128'(bus.mem_wb_addr), 128'h80);
        chk("t7_c1_wbdata", bus.mem_wb_data, 128'hA500_008C_A500_0088_A500_0084_A500_0080);
        nxt(); nxt(); mid();
        chk("t7_c3_rdreq",  128'(bus.mem_rd_req),  128'h1);
        chk("t7_c3_rdaddr", 128'(bus.mem_rd_addr), 128'h480);
        nxt(); nxt(); mid();
        chk("t7_c5_ready",  128'(bus.cpu_ready),   128'h1);
        chk("t7_c5_rdata",  128'(bus.cpu_rdata),   128'hA500_0480);
        nxt();
        bus.cpu_req = 1'b0;
        nxt();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
